// File: rtl/debug_pkg.sv
// debug_pkg: command bytes and FSM encoding shared by the debug RX decoder, debug TX and host script
package debug_pkg;

    localparam logic [7:0] CMD_RUN  = 8'h52;
    localparam logic [7:0] CMD_HALT = 8'h48;
    localparam logic [7:0] CMD_STEP = 8'h53;
    localparam logic [7:0] CMD_DUMP = 8'h44;
    localparam logic [7:0] CMD_CLR  = 8'h43;
    localparam logic [7:0] CMD_LOAD = 8'h4C;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_LD_ADDR_HI = 3'd1;
    localparam logic [2:0] ST_LD_ADDR_LO = 3'd2;
    localparam logic [2:0] ST_LD_DATA    = 3'd3;
    localparam logic [2:0] ST_WRITE      = 3'd4;
    localparam logic [2:0] ST_DUMP_WAIT  = 3'd5;

    function automatic logic is_load_state(input logic [2:0] s);
        return s == ST_LD_ADDR_HI || s == ST_LD_ADDR_LO || s == ST_LD_DATA;
    endfunction

endpackage

// File: rtl/debug_timeout_counter.sv
// debug_timeout_counter: counts stalled cycles and pulses expired_o on the TIMEOUT-th one
module debug_timeout_counter #(
    parameter int TIMEOUT = 1000000,
    parameter int TO_W    = 20
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] cnt_q, cnt_d;

    assign expired_o = en_i && !clr_i && cnt_q == LAST;

    // Restart on clear or expiry, otherwise advance while enabled
    always_comb begin
        cnt_d = (clr_i || expired_o) ? '0 : en_i ? cnt_q + TO_W'(1) : cnt_q;
    end

    // Counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/debug_command_decoder.sv
// debug_command_decoder: parses host command frames from the UART RX FIFO and drives pipeline control
module debug_command_decoder
    import debug_pkg::*;
#(
    parameter int ADDR_W  = 11,
    parameter int TIMEOUT = 1000000,
    parameter int TO_W    = 20
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_empty,
    output logic              rd_uart,
    output logic              pipe_ce,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              dump_req,
    input  logic              dump_busy,
    output logic              cmd_error,
    output logic              halted
);

    logic [2:0]        state_q, state_d;
    logic              rd_q, rd_d;
    logic              step_q, step_d;
    logic              we_q, we_d;
    logic              dump_q, dump_d;
    logic              err_q, err_d;
    logic              halted_q, halted_d;
    logic [1:0]        idx_q, idx_d;
    logic [7:0]        hi_q, hi_d, lo_q, lo_d;
    logic [31:0]       data_q, data_d, wdata_q, wdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              in_ld, intake, expired, oor;
    logic [15:0]       full_addr;

    assign in_ld     = is_load_state(state_q);
    assign intake    = in_ld || state_q == ST_IDLE;
    assign full_addr = {hi_q, lo_q};
    assign oor       = (full_addr >> ADDR_W) != 16'd0;

    // Stall timer for load frames; any pop or leaving the frame restarts it
    debug_timeout_counter #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_timeout (
        .clk_i     (clock),
        .rst_ni    (reset_n),
        .clr_i     (rd_q || !in_ld),
        .en_i      (in_ld && rx_empty),
        .expired_o (expired)
    );

    // Frame FSM: a byte is handled in the cycle its pop strobe is high, staged fields commit only in WRITE
    always_comb begin
        state_d  = state_q;
        rd_d     = intake && !rx_empty && !rd_q;
        step_d   = 1'b0;
        we_d     = 1'b0;
        dump_d   = 1'b0;
        err_d    = err_q;
        halted_d = halted_q;
        idx_d    = idx_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        data_d   = data_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        case (state_q)
            ST_IDLE: if (rd_q) begin
                if (rx_data == CMD_RUN)       halted_d = 1'b0;
                else if (rx_data == CMD_HALT) halted_d = 1'b1;
                else if (rx_data == CMD_STEP) step_d = halted_q;
                else if (rx_data == CMD_DUMP) state_d = ST_DUMP_WAIT;
                else if (rx_data == CMD_CLR)  err_d = 1'b0;
                else if (rx_data == CMD_LOAD) begin
                    if (halted_q) state_d = ST_LD_ADDR_HI;
                    else          err_d = 1'b1;
                end
                else err_d = 1'b1;
            end
            ST_LD_ADDR_HI: if (rd_q) begin
                hi_d    = rx_data;
                state_d = ST_LD_ADDR_LO;
            end
            ST_LD_ADDR_LO: if (rd_q) begin
                lo_d    = rx_data;
                idx_d   = 2'd0;
                state_d = ST_LD_DATA;
            end
            ST_LD_DATA: if (rd_q) begin
                data_d[{~idx_q, 3'b000} +: 8] = rx_data;
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
                if (oor) err_d = 1'b1;
                else begin
                    we_d    = 1'b1;
                    addr_d  = full_addr[ADDR_W-1:0];
                    wdata_d = data_q;
                end
            end
            ST_DUMP_WAIT: if (!dump_busy) begin
                dump_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (expired) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
        end
    end

    // State and datapath registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            rd_q     <= 1'b0;
            step_q   <= 1'b0;
            we_q     <= 1'b0;
            dump_q   <= 1'b0;
            err_q    <= 1'b0;
            halted_q <= 1'b1;
            idx_q    <= 2'd0;
            hi_q     <= 8'd0;
            lo_q     <= 8'd0;
            data_q   <= 32'd0;
            addr_q   <= '0;
            wdata_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            rd_q     <= rd_d;
            step_q   <= step_d;
            we_q     <= we_d;
            dump_q   <= dump_d;
            err_q    <= err_d;
            halted_q <= halted_d;
            idx_q    <= idx_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            data_q   <= data_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign rd_uart    = rd_q;
    assign pipe_ce    = !halted_q || step_q;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign dump_req   = dump_q;
    assign cmd_error  = err_q;
    assign halted     = halted_q;

endmodule

// File: tb/tb_debug_command_decoder.sv
// tb_debug_command_decoder: directed scenarios against a FIFO model with hand-computed expectations
module tb_debug_command_decoder;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_empty = 1'b1;
    logic        rd_uart, pipe_ce, imem_we, dump_req, cmd_error, halted;
    logic        dump_busy = 1'b0;
    logic [10:0] imem_addr;
    logic [31:0] imem_wdata;

    logic [7:0]  fifo[$];
    int          n_pass = 0, n_total = 0;
    int          rd_cnt, we_cnt, ce_cnt, dump_cnt, rd_consec;
    logic        prev_rd;
    logic [10:0] last_addr;
    logic [31:0] last_data;

    debug_command_decoder #(.ADDR_W(11), .TIMEOUT(16), .TO_W(5)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .rx_data    (rx_data),
        .rx_empty   (rx_empty),
        .rd_uart    (rd_uart),
        .pipe_ce    (pipe_ce),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .dump_req   (dump_req),
        .dump_busy  (dump_busy),
        .cmd_error  (cmd_error),
        .halted     (halted)
    );

    always #5 clock = ~clock;

    task automatic refresh_rx();
        rx_empty = fifo.size() == 0;
        rx_data  = fifo.size() == 0 ? 8'd0 : fifo[0];
    endtask

    task automatic push(input logic [7:0] b);
        fifo.push_back(b);
        refresh_rx();
    endtask

    task automatic clear_counts();
        rd_cnt = 0; we_cnt = 0; ce_cnt = 0; dump_cnt = 0; rd_consec = 0;
    endtask

    task automatic tick(input int n);
        logic [7:0] tmp;
        logic pop;
        for (int i = 0; i < n; i++) begin
            pop = rd_uart;
            prev_rd = rd_uart;
            @(posedge clock);
            #1;
            if (pop && fifo.size() > 0) tmp = fifo.pop_front();
            refresh_rx();
            if (rd_uart) rd_cnt++;
            if (rd_uart && prev_rd) rd_consec++;
            if (pipe_ce) ce_cnt++;
            if (dump_req) dump_cnt++;
            if (imem_we) begin
                we_cnt++;
                last_addr = imem_addr;
                last_data = imem_wdata;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        fifo.delete();
        refresh_rx();
        tick(2);
        reset_n = 1'b1;
        tick(1);
        n_total++;
        if ({rd_uart, pipe_ce, imem_we, dump_req, cmd_error, halted} !== 6'b000001) begin
            $display("FAIL reset_flags got=%b want=000001", {rd_uart, pipe_ce, imem_we, dump_req, cmd_error, halted});
        end else n_pass++;
        n_total++;
        if (imem_addr !== 11'd0 || imem_wdata !== 32'd0) begin
            $display("FAIL reset_imem got addr=%h data=%h want 0/0", imem_addr, imem_wdata);
        end else n_pass++;
    endtask

    task automatic test_step();
        clear_counts();
        push(8'h53);
        tick(10);
        n_total++;
        if (ce_cnt !== 1) $display("FAIL step_pulses got=%0d want=1", ce_cnt);
        else n_pass++;
        n_total++;
        if (halted !== 1'b1 || cmd_error !== 1'b0) $display("FAIL step_state got halted=%b err=%b want 1/0", halted, cmd_error);
        else n_pass++;
    endtask

    task automatic test_load();
        clear_counts();
        push(8'h4C); push(8'h01); push(8'h23);
        push(8'hDE); push(8'hAD); push(8'hBE); push(8'hEF);
        tick(40);
        n_total++;
        if (rd_cnt !== 7) $display("FAIL load_pops got=%0d want=7", rd_cnt);
        else n_pass++;
        n_total++;
        if (rd_consec !== 0) $display("FAIL load_rd_consecutive got=%0d want=0", rd_consec);
        else n_pass++;
        n_total++;
        if (we_cnt !== 1) $display("FAIL load_writes got=%0d want=1", we_cnt);
        else n_pass++;
        n_total++;
        if (last_addr !== 11'h123 || last_data !== 32'hDEADBEEF)
            $display("FAIL load_payload got addr=%h data=%h want 123/deadbeef", last_addr, last_data);
        else n_pass++;
        n_total++;
        if (cmd_error !== 1'b0 || imem_addr !== 11'h123) $display("FAIL load_hold got err=%b addr=%h want 0/123", cmd_error, imem_addr);
        else n_pass++;
    endtask

    task automatic test_out_of_range();
        clear_counts();
        push(8'h4C); push(8'h08); push(8'h00);
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        tick(40);
        n_total++;
        if (we_cnt !== 0 || cmd_error !== 1'b1) $display("FAIL oor_reject got writes=%0d err=%b want 0/1", we_cnt, cmd_error);
        else n_pass++;
        n_total++;
        if (imem_addr !== 11'h123 || imem_wdata !== 32'hDEADBEEF)
            $display("FAIL oor_hold got addr=%h data=%h want 123/deadbeef", imem_addr, imem_wdata);
        else n_pass++;
        push(8'h43);
        tick(6);
        n_total++;
        if (cmd_error !== 1'b0) $display("FAIL oor_clear got err=%b want 0", cmd_error);
        else n_pass++;
    endtask

    task automatic test_run_load();
        clear_counts();
        push(8'h52); push(8'h4C);
        tick(20);
        n_total++;
        if (pipe_ce !== 1'b1 || halted !== 1'b0 || ce_cnt < 15)
            $display("FAIL run_ce got ce=%b halted=%b ce_cycles=%0d want 1/0/>=15", pipe_ce, halted, ce_cnt);
        else n_pass++;
        n_total++;
        if (cmd_error !== 1'b1 || we_cnt !== 0) $display("FAIL run_load_err got err=%b writes=%0d want 1/0", cmd_error, we_cnt);
        else n_pass++;
        push(8'h48); push(8'h43);
        tick(10);
        n_total++;
        if (pipe_ce !== 1'b0 || halted !== 1'b1 || cmd_error !== 1'b0)
            $display("FAIL halt_again got ce=%b halted=%b err=%b want 0/1/0", pipe_ce, halted, cmd_error);
        else n_pass++;
    endtask

    task automatic test_timeout();
        clear_counts();
        push(8'h4C); push(8'h00);
        tick(8);
        n_total++;
        if (cmd_error !== 1'b0) $display("FAIL timeout_early got err=%b want 0", cmd_error);
        else n_pass++;
        tick(30);
        n_total++;
        if (cmd_error !== 1'b1 || we_cnt !== 0) $display("FAIL timeout_abort got err=%b writes=%0d want 1/0", cmd_error, we_cnt);
        else n_pass++;
        push(8'h43);
        tick(6);
        n_total++;
        if (cmd_error !== 1'b0) $display("FAIL timeout_idle got err=%b want 0", cmd_error);
        else n_pass++;
        push(8'h4C); push(8'h02); push(8'h34);
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        tick(40);
        n_total++;
        if (we_cnt !== 1 || last_addr !== 11'h234 || last_data !== 32'h11223344)
            $display("FAIL timeout_reload got writes=%0d addr=%h data=%h want 1/234/11223344", we_cnt, last_addr, last_data);
        else n_pass++;
    endtask

    task automatic test_dump();
        clear_counts();
        dump_busy = 1'b1;
        push(8'h44);
        tick(4);
        push(8'h48);
        tick(46);
        n_total++;
        if (dump_cnt !== 0 || rd_cnt !== 1) $display("FAIL dump_wait got reqs=%0d pops=%0d want 0/1", dump_cnt, rd_cnt);
        else n_pass++;
        dump_busy = 1'b0;
        tick(1);
        n_total++;
        if (dump_req !== 1'b1) $display("FAIL dump_pulse got=%b want 1", dump_req);
        else n_pass++;
        tick(10);
        n_total++;
        if (dump_cnt !== 1 || rd_cnt !== 2) $display("FAIL dump_single got reqs=%0d pops=%0d want 1/2", dump_cnt, rd_cnt);
        else n_pass++;
    endtask

    task automatic test_reset_mid_load();
        clear_counts();
        push(8'h4C); push(8'h01); push(8'h00); push(8'hAA); push(8'hBB);
        tick(7);
        reset_n = 1'b0;
        #1;
        n_total++;
        if ({rd_uart, pipe_ce, imem_we, dump_req, cmd_error, halted} !== 6'b000001 || imem_addr !== 11'd0 || imem_wdata !== 32'd0)
            $display("FAIL midload_reset got flags=%b addr=%h data=%h want 000001/0/0",
                     {rd_uart, pipe_ce, imem_we, dump_req, cmd_error, halted}, imem_addr, imem_wdata);
        else n_pass++;
        fifo.delete();
        refresh_rx();
        tick(2);
        reset_n = 1'b1;
        tick(20);
        n_total++;
        if (we_cnt !== 0 || cmd_error !== 1'b0) $display("FAIL midload_nowrite got writes=%0d err=%b want 0/0", we_cnt, cmd_error);
        else n_pass++;
    endtask

    initial begin
        prev_rd = 1'b0;
        last_addr = '0;
        last_data = '0;
        clear_counts();
        test_reset();
        test_step();
        test_load();
        test_out_of_range();
        test_run_load();
        test_timeout();
        test_dump();
        test_reset_mid_load();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
